serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_sched_pkg.sv | 13 +
 rtl/sched_arbiter2.sv | 20 ++
 rtl/serial_add_sched.sv | 147 ++++++++++++++
 tb/tb_serial_add_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types for the two-requester serial-add scheduler.
package serial_sched_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

endpackage

// File: rtl/sched_arbiter2.sv
// Two-way one-hot grant; combinational, no state. When both request, the one
// that was not granted last wins, so a pointer tied to 1 yields fixed req0 priority.
module sched_arbiter2
    import serial_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (valid_i[0] && valid_i[1]) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Arbitrates two requesters onto one shared N-cycle serial adder; response N+2 cycles after accept,
// held until rsp_ready. SERIAL_SCHED_RR_EN selects round-robin, otherwise fixed req0 priority.
module serial_add_sched
    import serial_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         add_load,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           id_q, id_d;
    logic           rsp_id_q, rsp_id_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic [NUM_REQ-1:0] vld, gnt;
    logic               last_grant;
    logic               accept;

    assign vld = {req1_valid, req0_valid};

`ifdef SERIAL_SCHED_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt[1];
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = 1'b1;
`endif

    sched_arbiter2 u_arb (
        .valid_i (vld),
        .last_i  (last_grant),
        .grant_o (gnt)
    );

    // Ready is suppressed during the reset cycle even though the state may read IDLE.
    assign req0_ready = (state_q == S_IDLE) && !reset && gnt[0];
    assign req1_ready = (state_q == S_IDLE) && !reset && gnt[1];
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = gnt[1] ? req1_a : req0_a;
                    b_d     = gnt[1] ? req1_b : req0_b;
                    id_d    = gnt[1];
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    sum_d    = add_sum;
                    cout_d   = add_cout;
                    rsp_id_d = id_q;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign add_load  = (state_q == S_LOAD);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched with a bit-serial adder model on the shared adder port.
module tb_serial_add_sched;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [N-1:0] rsp_sum;
    logic         add_load;
    logic [N-1:0] add_a, add_b, add_sum;
    logic         add_cout;

    int total = 0;
    int bad   = 0;

    serial_add_sched #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .add_load   (add_load),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .add_cout   (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial adder: bit 0 at the load edge, one further bit per clock, full result after N-1 more edges.
    logic [N-1:0] ma, mb, macc;
    logic         mc;
    int           midx = N;

    always @(posedge clk) begin
        if (add_load) begin
            ma   <= add_a;
            mb   <= add_b;
            macc <= N'(add_a[0] ^ add_b[0]);
            mc   <= add_a[0] & add_b[0];
            midx <= 1;
        end else if (midx < N) begin
            macc[midx] <= ma[midx] ^ mb[midx] ^ mc;
            mc         <= (ma[midx] & mb[midx]) | (mc & (ma[midx] ^ mb[midx]));
            midx       <= midx + 1;
        end
    end

    assign add_sum  = macc;
    assign add_cout = mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called in the acceptance cycle; returns one cycle into the response.
    task automatic wait_rsp(input string tag, input logic [N-1:0] ea, input logic [N-1:0] eb,
                            input logic [N-1:0] es, input logic ec, input logic eid);
        int cyc   = 0;
        int loads = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (add_load) loads++;
            if (cyc == N + 1) begin
                check({tag, "_add_a"}, 32'(add_a), 32'(ea));
                check({tag, "_add_b"}, 32'(add_b), 32'(eb));
            end
        end while (!rsp_valid && cyc < 40);
        check({tag, "_lat"},  32'(cyc),   32'(N + 2));
        check({tag, "_load"}, 32'(loads), 32'd1);
        check({tag, "_sum"},  32'(rsp_sum),  32'(es));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
        check({tag, "_id"},   32'(rsp_id),   32'(eid));
    endtask

    typedef struct {
        int           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[4];
    logic [N-1:0] rs_sum[4];
    logic         rs_id[4];
    logic         rs_cout[4];

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset values and ready gating during reset
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b0111;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_add_load", 32'(add_load), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("basic_ready", 32'(req0_ready), 32'd1);
        wait_rsp("basic", 4'b1010, 4'b0111, 4'b0001, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("basic_rsp_done", 32'(rsp_valid), 32'd0);
        check("basic_retain", 32'(rsp_sum), 32'b0001);

        // Simultaneous requests
        reset_dut();
        drive_req(0, 4'b0011, 4'b0001);
        drive_req(1, 4'b1111, 4'b0001);
        rsp_ready = 1'b1;
        begin
            int  nrsp = 0;
            int  g1   = 0;
            bit  drop0 = 0, drop1 = 0;
`ifdef SERIAL_SCHED_RR_EN
            int  want = 2;
            bit  keep0 = 0;
`else
            int  want = 4;
            bit  keep0 = 1;
`endif
            for (int c = 0; c < 60 && nrsp < want; c++) begin
                if (drop0) req0_valid = 1'b0;
                if (drop1) req1_valid = 1'b0;
                drop0 = 0; drop1 = 0;
                #1;
                if (req0_ready && !keep0) drop0 = 1;
                if (req1_ready) begin drop1 = 1; g1++; end
                if (rsp_valid) begin
                    rs_id[nrsp] = rsp_id; rs_sum[nrsp] = rsp_sum; rs_cout[nrsp] = rsp_cout;
                    nrsp++;
                end
                @(negedge clk);
            end
            check("arb_nrsp", 32'(nrsp), 32'(want));
`ifdef SERIAL_SCHED_RR_EN
            check("rr_id0", 32'(rs_id[0]), 32'd0);
            check("rr_sum0", 32'(rs_sum[0]), 32'b0100);
            check("rr_cout0", 32'(rs_cout[0]), 32'd0);
            check("rr_id1", 32'(rs_id[1]), 32'd1);
            check("rr_sum1", 32'(rs_sum[1]), 32'b0000);
            check("rr_cout1", 32'(rs_cout[1]), 32'd1);
`else
            check("fp_req1_grants", 32'(g1), 32'd0);
            for (int i = 0; i < 4; i++) begin
                check("fp_id", 32'(rs_id[i]), 32'd0);
                check("fp_sum", 32'(rs_sum[i]), 32'b0100);
            end
`endif
        end

        // Response backpressure with req1 waiting
        reset_dut();
        drive_req(0, 4'b0101, 4'b0110);
        #1;
        check("hold_ready0", 32'(req0_ready), 32'd1);
        wait_rsp("hold", 4'b0101, 4'b0110, 4'b1011, 1'b0, 1'b0);
        drive_req(1, 4'b1001, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_sum", 32'(rsp_sum), 32'b1011);
            check("hold_ready1", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("hs_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("hs_done", 32'(rsp_valid), 32'd0);
        check("hs_ready1_idle", 32'(req1_ready), 32'd1);
        check("hs_retain", 32'(rsp_sum), 32'b1011);
        wait_rsp("hold1", 4'b1001, 4'b1000, 4'b0001, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the second RUN cycle
        drive_req(0, 4'b0110, 4'b0011);
        #1;
        check("abort_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_req(1, 4'b0010, 4'b0011);
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_add_load", 32'(add_load), 32'd0);
        check("abort_add_a", 32'(add_a), 32'd0);
        check("abort_rsp_sum", 32'(rsp_sum), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        check("abort_idle_ready1", 32'(req1_ready), 32'd1);
        wait_rsp("post_rst", 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b1);

        // Back-to-back with rsp_ready high
        vecs[0] = '{0, 4'b1100, 4'b0101, 4'b0001, 1'b1};
        vecs[1] = '{1, 4'b0111, 4'b0111, 4'b1110, 1'b0};
        vecs[2] = '{0, 4'b1000, 4'b1000, 4'b0000, 1'b1};
        vecs[3] = '{1, 4'b0010, 4'b1101, 4'b1111, 1'b0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(vecs[i].id, vecs[i].a, vecs[i].b);
            #1;
            check("b2b_ready", 32'(vecs[i].id == 0 ? req0_ready : req1_ready), 32'd1);
            wait_rsp("b2b", vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'(vecs[i].id));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
